dtfm_frame_sequencer: RTL and testbench

Master-side timing controller for the DTFM serial word link. It generates the bit clock (dClk) and the frame marker (sync) that drive the serial word receiver, all from cClk.
It counts words per frame, turns each receiver `ready` rising edge into one write strobe into a frame buffer, and reports frame completion and word-count errors.
It sits between the frame buffer and the receiver, in the cClk domain.

---
 rtl/dtfm_pkg.sv | 20 ++
 rtl/dtfm_clk_div.sv | 43 ++++
 rtl/dtfm_frame_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_dtfm_frame_sequencer.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtfm_pkg.sv
// -----------------------------------------------------------------------------
// dtfm_pkg
// Shared types and constants for the DTFM frame sequencer.
//   stateT  : sequencer FSM states (IDLE, SYNC, RUN, GAP)
//   WORD_W  : width of one serial word / frame-buffer data word
//   ADDR_W  : width of the frame-buffer word address
// -----------------------------------------------------------------------------
package dtfm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      RUN  = 2'd2,
      GAP  = 2'd3
   } stateT;

   localparam int WORD_W = 16;
   localparam int ADDR_W = 10;

endpackage

// File: rtl/dtfm_clk_div.sv
// -----------------------------------------------------------------------------
// dtfm_clk_div
// Free-running cClk divider producing one "tick" every CLK_DIV cycles.
// Two ticks make one dClk period.
// Ports:
//   cClk  in  common clock
//   reset in  asynchronous active-low reset
//   run   in  count while high; counter held at 0 while low
//   clear in  force the counter back to 0
//   tick  out high in the cycle the counter sits at its terminal count
// -----------------------------------------------------------------------------
module dtfm_clk_div #(
   parameter int CLK_DIV = 4
) (
   input  logic cClk,
   input  logic reset,
   input  logic run,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] divCnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of block order.
   always_ff @(posedge cClk or negedge reset) begin
      if (!reset) begin
         divCnt <= '0;
      end else if (clear || !run) begin
         divCnt <= '0;
      end else if (divCnt == TERM) begin
         divCnt <= '0;
      end else begin
         divCnt <= divCnt + 1'b1;
      end
   end

   assign tick = run && !clear && (divCnt == TERM);

endmodule

// File: rtl/dtfm_frame_sequencer.sv
// -----------------------------------------------------------------------------
// dtfm_frame_sequencer
// Master-side timing controller for the DTFM serial word link. Generates the
// bit clock and frame marker, turns each receiver ready rising edge into one
// frame-buffer write, and flags word-count errors.
// Ports:
//   cClk       in   common clock (posedge)
//   reset      in   asynchronous active-low reset
//   enable     in   run frames back to back while high
//   rdy_in     in   receiver word-valid flag
//   word_in    in   receiver word bus
//   err_clr    in   clears the sticky error
//   dClk_out   out  serial bit clock
//   sync_out   out  frame marker
//   wr_en      out  one-cycle frame-buffer write strobe
//   wr_addr    out  word index within the frame
//   wr_data    out  word being written
//   frame_done out  pulses with the write of the last word of a frame
//   busy       out  high whenever the FSM is not idle
//   err        out  sticky word-count / protocol error
//   frame_cnt  out  completed-frame counter
// Build option: define DTFM_FRAME_CNT_EN to build the frame counter; without
// it frame_cnt is tied to zero.
// -----------------------------------------------------------------------------
module dtfm_frame_sequencer
   import dtfm_pkg::*;
#(
   parameter int CLK_DIV         = 4,
   parameter int WORDS_PER_FRAME = 8,
   parameter int SYNC_LEN        = 2,
   parameter int GAP_LEN         = 4
) (
   input  logic              cClk,
   input  logic              reset,
   input  logic              enable,
   input  logic              rdy_in,
   input  logic [WORD_W-1:0] word_in,
   input  logic              err_clr,
   output logic              dClk_out,
   output logic              sync_out,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic              frame_done,
   output logic              busy,
   output logic              err,
   output logic [15:0]       frame_cnt
);

   localparam logic [10:0] WPF       = 11'(WORDS_PER_FRAME);
   localparam logic [10:0] WPF_LAST  = 11'(WORDS_PER_FRAME - 1);
   localparam logic [13:0] BITS_LAST = 14'(WORDS_PER_FRAME * WORD_W - 1);
   localparam logic [15:0] SYNC_LAST = 16'(SYNC_LEN * 2 - 1);
   localparam logic [15:0] GAP_LAST  = 16'(GAP_LEN * 2 - 1);

   stateT       state, stateNext;
   logic [15:0] tickCnt, tickCntNext;
   logic [13:0] bitCnt, bitCntNext;
   logic [10:0] wordCnt, wordCntNext;
   logic        dClkNext;
   logic        wordClear;
   logic        tick;
   logic        rdyQ;

   logic rdyRise, inWindow, wrFire, lastWord, extraWord, badPhase;
   logic gapExit, shortFrame, errSet;

   dtfm_clk_div #(.CLK_DIV(CLK_DIV)) uClkDiv (
      .cClk  (cClk),
      .reset (reset),
      .run   (state != IDLE),
      .clear (state == IDLE),
      .tick  (tick)
   );

   // Write path and error conditions
   assign rdyRise   = rdy_in & ~rdyQ;
   assign inWindow  = (state == RUN) || (state == GAP);
   assign wrFire    = rdyRise && inWindow && (wordCnt < WPF);
   assign lastWord  = wrFire && (wordCnt == WPF_LAST);
   assign extraWord = rdyRise && inWindow && (wordCnt == WPF);
   assign badPhase  = rdyRise && ((state == IDLE) || (state == SYNC));
   assign gapExit   = (state == GAP) && tick && (tickCnt == GAP_LAST);
   // A word landing in the very cycle the gap closes still counts toward the frame.
   assign shortFrame = gapExit && (wrFire ? (wordCnt < WPF_LAST) : (wordCnt < WPF));
   assign errSet     = extraWord || badPhase || shortFrame;

   // NOTE: every signal driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      stateNext   = state;
      tickCntNext = tickCnt;
      bitCntNext  = bitCnt;
      dClkNext    = dClk_out;
      wordClear   = 1'b0;
      case (state)
         IDLE: begin
            dClkNext    = 1'b0;
            tickCntNext = '0;
            bitCntNext  = '0;
            if (enable) begin
               stateNext = SYNC;
               wordClear = 1'b1;
            end
         end
         SYNC: begin
            dClkNext = 1'b0;
            if (tick) begin
               if (tickCnt == SYNC_LAST) begin
                  stateNext   = RUN;
                  tickCntNext = '0;
               end else begin
                  tickCntNext = tickCnt + 16'd1;
               end
            end
         end
         RUN: begin
            if (tick) begin
               dClkNext = ~dClk_out;
               // dClk high at a tick means this tick is a falling edge.
               if (dClk_out) begin
                  if (bitCnt == BITS_LAST) begin
                     stateNext   = GAP;
                     bitCntNext  = '0;
                     tickCntNext = '0;
                  end else begin
                     bitCntNext = bitCnt + 14'd1;
                  end
               end
            end
         end
         GAP: begin
            dClkNext = 1'b0;
            if (tick) begin
               if (tickCnt == GAP_LAST) begin
                  tickCntNext = '0;
                  if (enable) begin
                     stateNext = SYNC;
                     wordClear = 1'b1;
                  end else begin
                     stateNext = IDLE;
                  end
               end else begin
                  tickCntNext = tickCnt + 16'd1;
               end
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   assign wordCntNext = wordClear ? 11'd0 : (wrFire ? wordCnt + 11'd1 : wordCnt);

   always_ff @(posedge cClk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         tickCnt    <= '0;
         bitCnt     <= '0;
         wordCnt    <= '0;
         rdyQ       <= 1'b0;
         dClk_out   <= 1'b0;
         sync_out   <= 1'b0;
         busy       <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= stateNext;
         tickCnt    <= tickCntNext;
         bitCnt     <= bitCntNext;
         wordCnt    <= wordCntNext;
         rdyQ       <= rdy_in;
         dClk_out   <= dClkNext;
         sync_out   <= (stateNext == SYNC);
         busy       <= (stateNext != IDLE);
         wr_en      <= wrFire;
         frame_done <= lastWord;
         if (wrFire) begin
            wr_addr <= wordCnt[ADDR_W-1:0];
            wr_data <= word_in;
         end
         // A new error in the same cycle as err_clr takes priority.
         if (errSet) begin
            err <= 1'b1;
         end else if (err_clr) begin
            err <= 1'b0;
         end
      end
   end

`ifdef DTFM_FRAME_CNT_EN
   logic [15:0] frameCnt;

   // Advances together with frame_done so both become visible in the same cycle.
   always_ff @(posedge cClk or negedge reset) begin
      if (!reset) begin
         frameCnt <= '0;
      end else if (lastWord) begin
         frameCnt <= frameCnt + 16'd1;
      end
   end

   assign frame_cnt = frameCnt;
`else
   assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dtfm_frame_sequencer.sv
`timescale 1ns/1ps
module tb_dtfm_frame_sequencer;

   localparam int CLK_DIV  = 2;
   localparam int WPF      = 4;
   localparam int SYNC_LEN = 2;
   localparam int GAP_LEN  = 4;

   logic        cClk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        err_clr = 1'b0;
   logic        rxRdy = 1'b0;
   logic        manRdy = 1'b0;
   logic [15:0] rxWord = 16'h0;
   logic [15:0] manWord = 16'h0;
   logic        rdy_in;
   logic [15:0] word_in;

   logic        dClk_out, sync_out, wr_en, frame_done, busy, err;
   logic [9:0]  wr_addr;
   logic [15:0] wr_data, frame_cnt;

   assign rdy_in  = rxRdy | manRdy;
   assign word_in = rxRdy ? rxWord : manWord;

   dtfm_frame_sequencer #(
      .CLK_DIV(CLK_DIV), .WORDS_PER_FRAME(WPF), .SYNC_LEN(SYNC_LEN), .GAP_LEN(GAP_LEN)
   ) dut (
      .cClk(cClk), .reset(reset), .enable(enable), .rdy_in(rdy_in), .word_in(word_in),
      .err_clr(err_clr), .dClk_out(dClk_out), .sync_out(sync_out), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done), .busy(busy),
      .err(err), .frame_cnt(frame_cnt)
   );

   always #5 cClk = ~cClk;

   typedef struct packed {
      logic [9:0]  addr;
      logic [15:0] data;
      logic        done;
   } wrExpT;

   wrExpT       sbQ[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          writesSeen = 0;
   int          frameDoneSeen = 0;
   bit          rxOn = 1'b0;
   int          rxLimit = 4;
   logic [15:0] rxData [4] = '{16'hA5A5, 16'h0001, 16'h8000, 16'hFFFF};

   // Receiver model: one word every 16 dClk falling edges of a frame.
   initial begin : receiver
      int   fallCnt;
      int   wordsThisFrame;
      int   hold;
      logic dPrev;
      fallCnt = 0; wordsThisFrame = 0; hold = 0; dPrev = 1'b0;
      forever begin
         @(negedge cClk);
         if (!rxOn || !reset) begin
            rxRdy = 1'b0; hold = 0; fallCnt = 0; wordsThisFrame = 0; dPrev = 1'b0;
         end else begin
            if (sync_out === 1'b1) begin
               fallCnt = 0;
               wordsThisFrame = 0;
            end
            if (hold > 0) begin
               hold--;
               if (hold == 0) rxRdy = 1'b0;
            end
            if (dPrev && !dClk_out) begin
               fallCnt++;
               if ((fallCnt % 16 == 0) && (wordsThisFrame < rxLimit)) begin
                  rxWord = rxData[wordsThisFrame[1:0]];
                  rxRdy  = 1'b1;
                  hold   = 2;
                  if (wordsThisFrame < WPF)
                     sbQ.push_back('{addr: 10'(wordsThisFrame), data: rxWord,
                                     done: (wordsThisFrame == WPF - 1)});
                  wordsThisFrame++;
               end
            end
            dPrev = dClk_out;
         end
      end
   end

   // Write monitor: every strobe must match the next expected beat.
   initial begin : monitor
      wrExpT e;
      forever begin
         @(negedge cClk);
         if (wr_en === 1'b1) begin
            writesSeen++;
            vectors++;
            if (sbQ.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_write: got addr=%0d data=%h, wanted no write", wr_addr, wr_data);
            end else begin
               e = sbQ.pop_front();
               if ({wr_addr, wr_data, frame_done} !== e) begin
                  miscompares++;
                  $display("FAIL write_beat: got addr=%0d data=%h done=%b, wanted addr=%0d data=%h done=%b",
                           wr_addr, wr_data, frame_done, e.addr, e.data, e.done);
               end
            end
         end else if (frame_done === 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_done_alone: frame_done high without wr_en");
         end
         if (frame_done === 1'b1) frameDoneSeen++;
      end
   end

   function automatic logic [15:0] exp_frame_cnt();
`ifdef DTFM_FRAME_CNT_EN
      return 16'(frameDoneSeen);
`else
      return 16'h0000;
`endif
   endfunction

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge cClk);
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pulse_enable();
      @(negedge cClk) enable = 1'b1;
      @(negedge cClk) enable = 1'b0;
   endtask

   task automatic pulse_err_clr();
      @(negedge cClk) err_clr = 1'b1;
      @(negedge cClk) err_clr = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge cClk);
      vectors++;
      if ({dClk_out, sync_out, wr_en, wr_addr, wr_data, frame_done, busy, err, frame_cnt} !== '0) begin
         miscompares++;
         $display("FAIL reset_values: got dclk=%b sync=%b wr=%b addr=%0d data=%h done=%b busy=%b err=%b cnt=%0d, wanted all 0",
                  dClk_out, sync_out, wr_en, wr_addr, wr_data, frame_done, busy, err, frame_cnt);
      end
      reset = 1'b1;
      repeat (2) @(negedge cClk);
      vectors++;
      if ({dClk_out, sync_out, busy, err, wr_en} !== 5'b0) begin
         miscompares++;
         $display("FAIL idle_after_reset: got dclk=%b sync=%b busy=%b err=%b wr=%b, wanted 0",
                  dClk_out, sync_out, busy, err, wr_en);
      end
   endtask

   task automatic test_single_frame();
      int   syncCnt, rises, falls, t0, tLastFall, tIdle, dHighInSync, wStart;
      logic dPrev, sPrev;
      syncCnt = 0; rises = 0; falls = 0; t0 = -1; tLastFall = -1; tIdle = -1;
      dHighInSync = 0; dPrev = 1'b0; sPrev = 1'b0;
      rxOn = 1'b1; rxLimit = 4; wStart = writesSeen;
      pulse_enable();
      vectors++;
      if (busy !== 1'b1 || sync_out !== 1'b1) begin
         miscompares++;
         $display("FAIL frame_start: got busy=%b sync=%b, wanted 1 1", busy, sync_out);
      end
      for (int t = 0; t < 1000 && tIdle < 0; t++) begin
         if (sync_out === 1'b1) syncCnt++;
         if (sync_out === 1'b1 && dClk_out === 1'b1) dHighInSync++;
         if (sPrev && !sync_out && t0 < 0) t0 = t;
         if (!dPrev && dClk_out) rises++;
         if (dPrev && !dClk_out) begin
            falls++;
            tLastFall = t;
         end
         if (busy === 1'b0) tIdle = t;
         sPrev = sync_out;
         dPrev = dClk_out;
         if (tIdle < 0) @(negedge cClk);
      end
      vectors++;
      if (tIdle < 0) begin
         miscompares++;
         $display("FAIL single_timeout: busy still %b after 1000 cycles, wanted 0", busy);
      end
      vectors++;
      if (syncCnt != 2 * SYNC_LEN * CLK_DIV || dHighInSync != 0) begin
         miscompares++;
         $display("FAIL sync_len: got %0d cycles (dclk high %0d), wanted 8 (0)", syncCnt, dHighInSync);
      end
      vectors++;
      if (rises != 64 || falls != 64) begin
         miscompares++;
         $display("FAIL dclk_edges: got rises=%0d falls=%0d, wanted 64 64", rises, falls);
      end
      vectors++;
      if (tLastFall - t0 != 256) begin
         miscompares++;
         $display("FAIL run_len: got %0d cycles, wanted 256", tLastFall - t0);
      end
      vectors++;
      if (tIdle - tLastFall != 16) begin
         miscompares++;
         $display("FAIL gap_len: got %0d cycles, wanted 16", tIdle - tLastFall);
      end
      repeat (2) @(negedge cClk);
      vectors++;
      if (writesSeen - wStart != 4 || sbQ.size() != 0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL single_frame: got writes=%0d pending=%0d err=%b, wanted 4 0 0",
                  writesSeen - wStart, sbQ.size(), err);
      end
      vectors++;
      if (frame_cnt !== exp_frame_cnt()) begin
         miscompares++;
         $display("FAIL frame_cnt_single: got %0d, wanted %0d", frame_cnt, exp_frame_cnt());
      end
   endtask

   task automatic test_multi_frame();
      int   syncRises, wStart, dStart;
      bit   ok;
      logic sPrev;
      syncRises = 0; sPrev = 1'b0; ok = 1'b0;
      wStart = writesSeen; dStart = frameDoneSeen;
      @(negedge cClk) enable = 1'b1;
      for (int t = 0; t < 3000; t++) begin
         @(negedge cClk);
         if (!sPrev && sync_out === 1'b1) begin
            syncRises++;
            if (syncRises == 3) enable = 1'b0;
         end
         sPrev = sync_out;
         if (t > 0 && busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      enable = 1'b0;
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL multi_timeout: busy still %b, wanted 0", busy);
      end
      repeat (2) @(negedge cClk);
      vectors++;
      if (syncRises != 3 || frameDoneSeen - dStart != 3 || writesSeen - wStart != 12) begin
         miscompares++;
         $display("FAIL multi_frame: got syncs=%0d frames=%0d writes=%0d, wanted 3 3 12",
                  syncRises, frameDoneSeen - dStart, writesSeen - wStart);
      end
      vectors++;
      if (frame_cnt !== exp_frame_cnt() || err !== 1'b0) begin
         miscompares++;
         $display("FAIL frame_cnt_multi: got cnt=%0d err=%b, wanted cnt=%0d err=0",
                  frame_cnt, err, exp_frame_cnt());
      end
   endtask

   task automatic test_short_frame();
      int wStart;
      bit ok;
      rxLimit = 3; wStart = writesSeen;
      pulse_enable();
      wait_idle(1000, ok);
      vectors++;
      if (!ok || err !== 1'b1 || writesSeen - wStart != 3) begin
         miscompares++;
         $display("FAIL short_frame: got idle=%b err=%b writes=%0d, wanted 1 1 3",
                  ok, err, writesSeen - wStart);
      end
      rxLimit = 4;
      pulse_err_clr();
      vectors++;
      if (err !== 1'b0) begin
         miscompares++;
         $display("FAIL err_clr: got err=%b, wanted 0", err);
      end
      @(negedge cClk);
      manWord = 16'h1234; manRdy = 1'b1; err_clr = 1'b1;
      @(negedge cClk);
      manRdy = 1'b0; err_clr = 1'b0;
      vectors++;
      if (err !== 1'b1 || wr_en !== 1'b0) begin
         miscompares++;
         $display("FAIL set_beats_clr: got err=%b wr=%b, wanted 1 0", err, wr_en);
      end
   endtask

   task automatic test_idle_rdy();
      int wrCount;
      wrCount = 0;
      pulse_err_clr();
      vectors++;
      if (err !== 1'b0) begin
         miscompares++;
         $display("FAIL err_clr_idle: got err=%b, wanted 0", err);
      end
      @(negedge cClk) begin manWord = 16'hBEEF; manRdy = 1'b1; end
      repeat (3) begin
         @(negedge cClk);
         if (wr_en === 1'b1) wrCount++;
      end
      manRdy = 1'b0;
      repeat (3) begin
         @(negedge cClk);
         if (wr_en === 1'b1) wrCount++;
      end
      vectors++;
      if (err !== 1'b1 || wrCount != 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_rdy: got err=%b writes=%0d busy=%b, wanted 1 0 0", err, wrCount, busy);
      end
   endtask

   task automatic test_enable_drop();
      int   wStart, syncRises;
      bit   inRun, ok;
      logic sPrev;
      pulse_err_clr();
      wStart = writesSeen; syncRises = 0; inRun = 1'b0; ok = 1'b0; sPrev = 1'b0;
      @(negedge cClk) enable = 1'b1;
      for (int t = 0; t < 1500; t++) begin
         @(negedge cClk);
         if (!sPrev && sync_out === 1'b1) syncRises++;
         if (sPrev && sync_out === 1'b0) inRun = 1'b1;
         sPrev = sync_out;
         if (inRun && t == 60) enable = 1'b0;
         if (t > 0 && busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      enable = 1'b0;
      repeat (2) @(negedge cClk);
      vectors++;
      if (!ok || syncRises != 1 || writesSeen - wStart != 4 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL enable_drop: got idle=%b syncs=%0d writes=%0d err=%b, wanted 1 1 4 0",
                  ok, syncRises, writesSeen - wStart, err);
      end
   endtask

   task automatic test_reset_mid_run();
      int   wStart;
      bit   ok;
      logic sPrev;
      sPrev = 1'b0;
      pulse_enable();
      for (int t = 0; t < 100; t++) begin
         @(negedge cClk);
         if (sPrev && sync_out === 1'b0) break;
         sPrev = sync_out;
      end
      repeat (100) @(negedge cClk);
      vectors++;
      if (busy !== 1'b1 || writesSeen == 0) begin
         miscompares++;
         $display("FAIL mid_run_state: got busy=%b writes=%0d, wanted busy=1 and writes>0", busy, writesSeen);
      end
      #2 reset = 1'b0;
      #1;
      vectors++;
      if ({dClk_out, sync_out, wr_en, wr_addr, wr_data, frame_done, busy, err, frame_cnt} !== '0) begin
         miscompares++;
         $display("FAIL async_reset: got dclk=%b sync=%b wr=%b addr=%0d data=%h busy=%b cnt=%0d, wanted all 0",
                  dClk_out, sync_out, wr_en, wr_addr, wr_data, busy, frame_cnt);
      end
      repeat (3) @(negedge cClk);
      sbQ.delete();
      frameDoneSeen = 0;
      reset = 1'b1;
      repeat (2) @(negedge cClk);
      wStart = writesSeen;
      pulse_enable();
      wait_idle(1000, ok);
      repeat (2) @(negedge cClk);
      vectors++;
      if (!ok || writesSeen - wStart != 4 || err !== 1'b0 || sbQ.size() != 0) begin
         miscompares++;
         $display("FAIL restart_frame: got idle=%b writes=%0d err=%b pending=%0d, wanted 1 4 0 0",
                  ok, writesSeen - wStart, err, sbQ.size());
      end
      vectors++;
      if (frame_cnt !== exp_frame_cnt()) begin
         miscompares++;
         $display("FAIL frame_cnt_restart: got %0d, wanted %0d", frame_cnt, exp_frame_cnt());
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_multi_frame();
      test_short_frame();
      test_idle_rdy();
      test_enable_drop();
      test_reset_mid_run();
      vectors++;
      if (sbQ.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending writes, wanted 0", sbQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
